// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bits out.
// Optional trailing even-parity bit per frame when SER_PARITY_EN is defined.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SER_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] hold, hold_d;
  logic             hold_valid, hold_valid_d;
  logic             dout_d, dout_valid_d, frame_start_d;
  logic             accept, load, retire;
  logic [WIDTH-1:0] load_word;
`ifdef SER_PARITY_EN
  logic             par, par_d;
`endif

  assign data_ready = !hold_valid;
  assign accept     = data_valid && data_ready;
  assign busy       = (state != IDLE) || hold_valid;

  // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state;
    sh_d          = sh;
    cnt_d         = cnt;
    hold_d        = hold;
    hold_valid_d  = hold_valid;
    dout_d        = dout;
    dout_valid_d  = dout_valid;
    frame_start_d = frame_start;
    load          = 1'b0;
    load_word     = data_in;
    retire        = 1'b0;
`ifdef SER_PARITY_EN
    par_d         = par;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
        end else begin
          dout_d        = 1'b0;
          dout_valid_d  = 1'b0;
          frame_start_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt < LAST) begin
          dout_d        = sh[WIDTH-1];
          sh_d          = sh << 1;
          cnt_d         = cnt + CW'(1);
          frame_start_d = 1'b0;
          if (accept) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
          end
        end else begin
`ifdef SER_PARITY_EN
          dout_d        = par;
          frame_start_d = 1'b0;
          state_d       = PARITY;
          if (accept) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
          end
`else
          retire = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: retire = 1'b1;
`endif
      default: state_d = IDLE;
    endcase

    // A held word takes priority; a fresh word on the retire edge keeps the stream gapless.
    if (retire) begin
      if (hold_valid) begin
        load         = 1'b1;
        load_word    = hold;
        hold_valid_d = 1'b0;
      end else if (accept) begin
        load = 1'b1;
      end else begin
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        state_d       = IDLE;
      end
    end

    if (load) begin
      dout_d        = load_word[WIDTH-1];
      dout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
      sh_d          = load_word << 1;
      cnt_d         = CW'(1);
      state_d       = SHIFT;
`ifdef SER_PARITY_EN
      par_d         = ^load_word;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
`ifdef SER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      sh          <= sh_d;
      cnt         <= cnt_d;
      hold        <= hold_d;
      hold_valid  <= hold_valid_d;
      dout        <= dout_d;
      dout_valid  <= dout_valid_d;
      frame_start <= frame_start_d;
`ifdef SER_PARITY_EN
      par         <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: accepted words expand into an expected bit stream
// that a monitor compares against dout every cycle. Honours SER_PARITY_EN like the RTL.
module tb_bit_serializer;

  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             data_valid = 1'b0;
  logic             data_ready, dout, dout_valid, frame_start, busy;

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .dout(dout), .dout_valid(dout_valid),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic fs;
    int   id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   word_id  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Reference: a word becomes its bits MSB first, then an even-parity bit if enabled.
  always @(posedge clk) begin
    if (!rst && data_valid && data_ready) begin
      for (int k = 0; k < WIDTH; k++)
        exp_q.push_back('{b: data_in[WIDTH-1-k], fs: (k == 0), id: word_id});
`ifdef SER_PARITY_EN
      exp_q.push_back('{b: logic'($countones(data_in) % 2), fs: 1'b0, id: word_id});
`endif
      word_id++;
    end
  end

  // Pending bits are always streamed back to back; a second pending word means hold is full.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      check("dout_valid", dout_valid, exp_q.size() != 0);
      check("busy", busy, exp_q.size() != 0);
      check("data_ready", data_ready,
            !(exp_q.size() != 0 && exp_q[0].id != exp_q[$].id));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dout", dout, e.b);
        check("frame_start", frame_start, e.fs);
      end else begin
        check("idle_dout", dout, 0);
        check("idle_frame_start", frame_start, 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] w);
    int n = 0;
    data_in    = w;
    data_valid = 1'b1;
    while (!data_ready && n < 4 * FLEN) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = WIDTH'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_data_ready"}, data_ready, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    #1;
    check_reset_outputs("rst_hold");
    idle(2);
    rst = 1'b0;
    idle(1);
    check_reset_outputs("post_rst");

    // Single frame, then idle.
    send(8'hB4);
    idle(FLEN + 3);

    // Second word held behind the first.
    send(8'hB4);
    send(8'h0B);
    idle(2 * FLEN + 3);

    // Parity-relevant pair and four words with data_valid held.
    send(8'h0B);
    send(8'hB4);
    send(8'h5A);
    send(8'hC3);
    send(8'h01);
    send(8'h80);
    idle(4 * FLEN + 3);

    // Asynchronous reset while the frame is mid-way and a word is held.
    send(8'hB4);
    send(8'h0B);
    idle(2);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    check_reset_outputs("rst_release");
    send(8'hFF);
    idle(FLEN + 2);

    // Random words with random gaps, including arrivals on the retire edge.
    for (int i = 0; i < 60; i++) begin
      send(WIDTH'($urandom));
      idle($urandom_range(0, FLEN + 1));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20 * FLEN) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial-input state machines, such as the sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on a registered `dout`/`dout_valid` pair that connects directly to a detector's `din`. A one-word holding register lets back-to-back words stream with no idle gap.

## Interface
- WIDTH, 8: word width in bits, must be at least 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- data_in  input  WIDTH  parallel word to serialize.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  block can accept a word. Equals !hold_valid, decoded from registered state, with no combinational path from data_valid.
- dout  output  1  registered serial bit.
- dout_valid  output  1  dout carries a live bit.
- frame_start  output  1  high while dout holds the first (MSB) bit of a word.
- busy  output  1  word in flight or held: (state != IDLE) || hold_valid.

## Operation
- Internal state:
  - shift register sh[WIDTH-1:0]
  - bit counter cnt, $clog2(WIDTH)+1 bits
  - hold register hold[WIDTH-1:0] with hold_valid
  - stored parity bit par
  - FSM with states IDLE, SHIFT, PARITY. PARITY exists only with the macro (see Configuration).
- Accept: data_valid && data_ready at a rising edge.
- Load of word W, performed at a clock edge:
  - dout <= W[WIDTH-1]; dout_valid <= 1; frame_start <= 1.
  - sh <= W << 1; cnt <= 1; par <= ^W; state <= SHIFT.
- IDLE:
  - On accept, load data_in directly. hold is not used.
  - Otherwise stay in IDLE with dout = 0 and dout_valid = 0.
- SHIFT with cnt < WIDTH:
  - dout <= sh[WIDTH-1]; sh <= sh << 1; cnt <= cnt + 1; frame_start <= 0.
  - An accept in this state writes hold and sets hold_valid.
- SHIFT with cnt == WIDTH (the last data bit is on dout):
  - Without the macro, retire the word:
    - if hold_valid, load hold and clear hold_valid;
    - else if an accept occurs this edge, load data_in directly and leave hold_valid at 0;
    - else dout <= 0, dout_valid <= 0, frame_start <= 0, state <= IDLE.
  - With the macro: dout <= par, frame_start <= 0, state <= PARITY. An accept this edge goes to hold.
- PARITY: retire the word exactly as described above for SHIFT at cnt == WIDTH.
- Hold overflow cannot occur because data_ready is low while hold_valid = 1. A data_valid asserted while data_ready is low is ignored and must be held by the source.
- data_in is sampled only on accept. Later changes to data_in never affect bits already in flight.

## Timing
- Reset values: dout = 0, dout_valid = 0, frame_start = 0, data_ready = 1, busy = 0, state = IDLE, hold_valid = 0, cnt = 0.
- Reset mid-word, asynchronous: the word in flight and the held word are both discarded, and all outputs return to their reset values immediately.
- Latency: a word accepted at edge N puts its MSB on dout in the cycle after edge N. Bit k (k = 0 is the MSB) appears after edge N+k.
- Frame period: WIDTH cycles, or WIDTH+1 with the macro.
- Gapless streaming: if the next word is held or arrives on the retire edge, its MSB immediately follows the last bit of the previous frame, and dout_valid never drops.
- Throughput: one word per frame period. data_ready drops for at most one frame period after hold is filled.

## Configuration
- SER_PARITY_EN defined: each frame is followed by one even-parity bit, par = XOR of all WIDTH data bits, with dout_valid = 1 and frame_start = 0. The PARITY state is present.
- SER_PARITY_EN undefined: no parity bit is sent. The PARITY state and the par register are not built, and frames are exactly WIDTH bits long.

## Test plan
- Reset, then WIDTH=8, accept 0xB4 at edge 1, no macro: dout = 1,0,1,1,0,1,0,0 on cycles 1-8, frame_start high only on cycle 1, dout_valid = 0 and busy = 0 from cycle 9.
- Accept 0xB4 and then 0x0B on the following cycle, held with data_ready low through the frame: 16 contiguous valid bits 10110100 00001011 with no gap, and frame_start high on cycles 1 and 9.
- Accept 0x0B with the SER_PARITY_EN macro: dout = 0,0,0,0,1,0,1,1 followed by parity bit 1, then 0xB4 gives a parity bit of 0. Frame period is 9.
- Hold data_valid = 1 for 4 words with data_ready toggling: every word is accepted exactly once, in order, with no bit lost or duplicated.
- Assert rst at bit 3 of 0xB4 while 0x0B is held: outputs go to reset values at once, and after release the next accepted word 0xFF serializes cleanly as eight 1s.
